// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline definitions: stage indices, controller state encoding and
// the priority helper that turns per-stage hold requests into a stall mask.
package pipeline_stall_ctrl_pkg;

  localparam int unsigned STAGE_IF    = 0;
  localparam int unsigned STAGE_ID    = 1;
  localparam int unsigned STAGE_EX    = 2;
  localparam int unsigned STAGE_MEM   = 3;
  localparam int unsigned STAGE_WB    = 4;
  localparam int unsigned STAGE_COUNT = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_BUS = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  // Highest requesting stage k holds stages k..0; everything older keeps moving.
  function automatic logic [STAGE_COUNT-1:0] stall_mask(input logic [STAGE_COUNT-1:0] req);
    logic [STAGE_COUNT-1:0] mask;
    logic                   seen;
    mask = '0;
    seen = 1'b0;
    for (int i = int'(STAGE_COUNT) - 1; i >= 0; i--) begin
      seen    = seen | req[i];
      mask[i] = seen;
    end
    return mask;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low reset.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller for the IF/ID/EX/MEM/WB pipeline: builds the
// per-stage stall vector and sequences bus-safe one-cycle flushes.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_req_if,
  input  logic                   stall_req_id,
  input  logic                   stall_req_ex,
  input  logic                   stall_req_mem,
  input  logic                   flush_req,
  input  logic [ADDR_WIDTH-1:0]  flush_pc_in,
  input  logic                   mem_busy,
  output logic [STAGE_COUNT-1:0] stall,
  output logic                   flush,
  output logic [ADDR_WIDTH-1:0]  flush_pc,
  output logic [CNT_WIDTH-1:0]   stall_cycles
);

  state_e                 r_state;
  logic                   r_flush;
  logic [ADDR_WIDTH-1:0]  r_flush_pc;
  logic [ADDR_WIDTH-1:0]  r_pend_pc;
  logic [STAGE_COUNT-1:0] w_req;
  logic [STAGE_COUNT-1:0] w_stall;

  always_comb begin
    w_req            = '0;
    w_req[STAGE_IF]  = stall_req_if;
    w_req[STAGE_ID]  = stall_req_id;
    w_req[STAGE_EX]  = stall_req_ex;
    w_req[STAGE_MEM] = stall_req_mem;
    w_req[STAGE_WB]  = 1'b0;
  end

  // Freeze the whole pipe from flush acceptance until the flush cycle itself.
  always_comb begin
    w_stall = '0;
    if (rst) begin
      case (r_state)
        RUN:      w_stall = flush_req ? '1 : stall_mask(w_req);
        WAIT_BUS: w_stall = '1;
        FLUSH:    w_stall = '0;
        default:  w_stall = '0;
      endcase
    end
  end

  // Flush sequencer; the pending PC is captured only on acceptance in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= RUN;
      r_flush    <= 1'b0;
      r_flush_pc <= '0;
      r_pend_pc  <= '0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        RUN: begin
          if (flush_req) begin
            r_pend_pc <= flush_pc_in;
            if (mem_busy) begin
              r_state <= WAIT_BUS;
            end else begin
              r_state    <= FLUSH;
              r_flush    <= 1'b1;
              r_flush_pc <= flush_pc_in;
            end
          end
        end
        WAIT_BUS: begin
          if (!mem_busy) begin
            r_state    <= FLUSH;
            r_flush    <= 1'b1;
            r_flush_pc <= r_pend_pc;
          end
        end
        FLUSH:   r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_stall[STAGE_IF]),
    .o_count(stall_cycles)
  );

  assign stall    = w_stall;
  assign flush    = r_flush;
  assign flush_pc = r_flush_pc;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: the driver queues hand-computed
// per-cycle expectations and a negedge monitor pops and compares them.
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem;
  logic        flush_req;
  logic [31:0] flush_pc_in;
  logic        mem_busy;
  logic [4:0]  stall, stall4;
  logic        flush, flush4;
  logic [31:0] flush_pc, flush_pc4;
  logic [31:0] stall_cycles;
  logic [3:0]  stall_cycles4;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       name;
    logic [4:0]  stall;
    logic        flush;
    logic        pc_chk;
    logic [31:0] pc;
    int          cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst),
    .stall_req_if(req_if), .stall_req_id(req_id),
    .stall_req_ex(req_ex), .stall_req_mem(req_mem),
    .flush_req(flush_req), .flush_pc_in(flush_pc_in), .mem_busy(mem_busy),
    .stall(stall), .flush(flush), .flush_pc(flush_pc), .stall_cycles(stall_cycles)
  );

  pipeline_stall_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .stall_req_if(req_if), .stall_req_id(req_id),
    .stall_req_ex(req_ex), .stall_req_mem(req_mem),
    .flush_req(flush_req), .flush_pc_in(flush_pc_in), .mem_busy(mem_busy),
    .stall(stall4), .flush(flush4), .flush_pc(flush_pc4), .stall_cycles(stall_cycles4)
  );

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (stall === e.stall) n_pass++;
      else $display("FAIL %s stall: got %b expected %b", e.name, stall, e.stall);
      n_checks++;
      if (flush === e.flush) n_pass++;
      else $display("FAIL %s flush: got %b expected %b", e.name, flush, e.flush);
      if (e.pc_chk) begin
        n_checks++;
        if (flush_pc === e.pc) n_pass++;
        else $display("FAIL %s flush_pc: got %h expected %h", e.name, flush_pc, e.pc);
      end
      if (e.cnt >= 0) begin
        logic [3:0] exp4;
        exp4 = (e.cnt > 15) ? 4'hF : 4'(e.cnt);
        n_checks++;
        if (stall_cycles === 32'(e.cnt)) n_pass++;
        else $display("FAIL %s stall_cycles: got %0d expected %0d", e.name, stall_cycles, e.cnt);
        n_checks++;
        if (stall_cycles4 === exp4) n_pass++;
        else $display("FAIL %s stall_cycles(4b): got %0d expected %0d", e.name, stall_cycles4, exp4);
      end
    end
  end

  // Drive one cycle of inputs and queue what the DUT must show in that cycle.
  task automatic cyc(input string name, input logic r,
                     input logic [3:0] req,          // {mem, ex, id, if}
                     input logic fr, input logic [31:0] fpc, input logic busy,
                     input logic [4:0] e_stall, input logic e_flush,
                     input logic e_pc_chk, input logic [31:0] e_pc, input int e_cnt);
    exp_t e;
    rst         = r;
    req_if      = req[0];
    req_id      = req[1];
    req_ex      = req[2];
    req_mem     = req[3];
    flush_req   = fr;
    flush_pc_in = fpc;
    mem_busy    = busy;
    e.name   = name;
    e.stall  = e_stall;
    e.flush  = e_flush;
    e.pc_chk = e_pc_chk;
    e.pc     = e_pc;
    e.cnt    = e_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; req_if = 1'b0; req_id = 1'b0; req_ex = 1'b0; req_mem = 1'b0;
    flush_req = 1'b0; flush_pc_in = '0; mem_busy = 1'b0;
    @(posedge clk);
    #1;
    // name         rst  req     fr    fpc           busy  stall     fl  pcchk  pc            cnt
    cyc("reset",    0, 4'b1000, 0, 32'h0,        0, 5'b00000, 0, 1, 32'h0,        0);
    cyc("pri_if_ex",1, 4'b0101, 0, 32'h0,        0, 5'b00111, 0, 1, 32'h0,        0);
    cyc("pri_if_id",1, 4'b0011, 0, 32'h0,        0, 5'b00011, 0, 0, 32'h0,        1);
    cyc("pri_mem",  1, 4'b1010, 0, 32'h0,        0, 5'b01111, 0, 0, 32'h0,        2);
    cyc("idle",     1, 4'b0000, 0, 32'h0,        0, 5'b00000, 0, 0, 32'h0,        3);
    cyc("imm_acc",  1, 4'b0000, 1, 32'hBFC00380, 0, 5'b11111, 0, 0, 32'h0,        3);
    cyc("imm_fl",   1, 4'b0000, 0, 32'h0,        0, 5'b00000, 1, 1, 32'hBFC00380, 4);
    cyc("imm_done", 1, 4'b0000, 0, 32'h0,        0, 5'b00000, 0, 1, 32'hBFC00380, 4);
    cyc("def_acc",  1, 4'b0000, 1, 32'hBFC00200, 1, 5'b11111, 0, 0, 32'h0,        4);
    cyc("def_w1",   1, 4'b0001, 0, 32'h0,        1, 5'b11111, 0, 0, 32'h0,        5);
    cyc("def_w2",   1, 4'b1000, 1, 32'h80000180, 1, 5'b11111, 0, 0, 32'h0,        6);
    cyc("def_w3",   1, 4'b0000, 0, 32'h0,        0, 5'b11111, 0, 0, 32'h0,        7);
    cyc("def_fl",   1, 4'b0100, 1, 32'h11110000, 0, 5'b00000, 1, 1, 32'hBFC00200, 8);
    cyc("def_done", 1, 4'b0000, 0, 32'h0,        0, 5'b00000, 0, 1, 32'hBFC00200, 8);
    cyc("def_ign",  1, 4'b0000, 0, 32'h0,        0, 5'b00000, 0, 1, 32'hBFC00200, 8);
    cyc("rw_acc",   1, 4'b0000, 1, 32'hDEAD0000, 1, 5'b11111, 0, 0, 32'h0,        8);
    cyc("rw_wait",  1, 4'b0000, 0, 32'h0,        1, 5'b11111, 0, 0, 32'h0,        9);
    cyc("rw_rst",   0, 4'b0000, 0, 32'h0,        1, 5'b00000, 0, 1, 32'hBFC00200, 10);
    cyc("rw_mem",   1, 4'b1000, 0, 32'h0,        1, 5'b01111, 0, 1, 32'h0,        0);
    cyc("rw_nofl1", 1, 4'b0000, 0, 32'h0,        0, 5'b00000, 0, 1, 32'h0,        1);
    cyc("rw_nofl2", 1, 4'b0000, 0, 32'h0,        0, 5'b00000, 0, 1, 32'h0,        1);
    cyc("cnt_rst",  0, 4'b0000, 0, 32'h0,        0, 5'b00000, 0, 1, 32'h0,        1);
    for (int i = 0; i < 10; i++)
      cyc("cnt_id",  1, 4'b0010, 0, 32'h0,        0, 5'b00011, 0, 0, 32'h0,        i);
    cyc("cnt_10",   1, 4'b0000, 0, 32'h0,        0, 5'b00000, 0, 0, 32'h0,        10);
    for (int i = 0; i < 10; i++)
      cyc("cnt_sat", 1, 4'b0010, 0, 32'h0,        0, 5'b00011, 0, 0, 32'h0,        10 + i);
    cyc("cnt_20",   1, 4'b0000, 0, 32'h0,        0, 5'b00000, 0, 0, 32'h0,        20);
    cyc("cnt_hold", 1, 4'b0000, 0, 32'h0,        0, 5'b00000, 0, 0, 32'h0,        20);

    repeat (2) @(posedge clk);
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d queued expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Gathers per-stage stall requests and exception/ERET flush requests, and drives the per-stage stall vector consumed by every inter-stage pipeline register.
- The vector encodes the hold/bubble semantics those registers use: stall[i] && !stall[i+1] inserts a bubble after stage i.
- Defers a flush while a MEM bus transaction is in flight, then issues a one-cycle registered flush with the redirect PC.

Parameters:
- ADDR_WIDTH, 32, width of flush target PC.
- CNT_WIDTH, 32, width of stall-cycle performance counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low
- stall_req_if  input  1  IF hold request (icache miss)
- stall_req_id  input  1  ID hold request (load-use hazard)
- stall_req_ex  input  1  EX hold request (multi-cycle mul/div)
- stall_req_mem  input  1  MEM hold request (dcache miss)
- flush_req  input  1  exception/ERET redirect request
- flush_pc_in  input  ADDR_WIDTH  redirect target, valid with flush_req
- mem_busy  input  1  outstanding MEM bus transaction, must not be killed
- stall  output  5  bit0=IF … bit4=WB; 1 = stage holds
- flush  output  1  one-cycle pipeline flush pulse
- flush_pc  output  ADDR_WIDTH  redirect target, valid while flush=1
- stall_cycles  output  CNT_WIDTH  count of cycles with stall[0]=1, saturating

Behaviour:
- Reset (rst=0 at posedge):
  - state=RUN.
  - flush=0, flush_pc=0, stall_cycles=0.
  - stall=5'b00000 combinationally while rst=0.
- Stall vector in RUN with no flush_req is combinational, zero latency. The highest requesting stage k sets stall[k:0]=1 and stall[4:k+1]=0.
  - mem → 5'b01111, ex → 5'b00111, id → 5'b00011, if → 5'b00001. None → 0.
  - WB never stalls in RUN.
  - Multiple requests: the highest stage wins. The vector is always a contiguous low-order mask.
- States:
  - RUN: flush_req=1 latches flush_pc_in into a pending register. Next state is WAIT_BUS if mem_busy=1, else FLUSH. In the accept cycle stall=5'b11111 so nothing younger advances.
  - WAIT_BUS: stall=5'b11111. Stay while mem_busy=1. When mem_busy=0 → FLUSH.
  - FLUSH: flush=1 (registered, asserted in this state only), flush_pc=pending PC, stall=5'b00000. Next → RUN unconditionally.
- Flush latency: accept cycle N with mem_busy=0 → flush=1 in cycle N+1, exactly one cycle.
- flush_req in WAIT_BUS or FLUSH is ignored. The first accepted request wins and the pending PC is not overwritten.
- Stall requests during WAIT_BUS or FLUSH are ignored for the vector.
- flush_pc holds its last value when flush=0.
- stall_cycles increments at each posedge where stall[0]=1 and rst=1. It saturates at all-ones with no wrap.
- Reset mid-WAIT_BUS or mid-FLUSH: return to RUN, discard the pending PC, and emit no flush.

Decomposition:
- Shared pipeline package holds:
  - stall-vector bit index constants: STAGE_IF=0, STAGE_ID=1, STAGE_EX=2, STAGE_MEM=3, STAGE_WB=4.
  - STAGE_COUNT=5.
  - state encoding constants RUN/WAIT_BUS/FLUSH.
- One natural sub-module: sat_counter (parameterised width, enable, synchronous active-low reset, saturating). It implements stall_cycles.

Test Plan:
- Priority mask: after reset, stall_req_if=1 and stall_req_ex=1 together → stall=5'b00111, flush=0. With all requests at 0 → stall=0 in the same cycle.
- Immediate flush: flush_req=1, flush_pc_in=32'hBFC00380, mem_busy=0 at cycle N:
  - stall=5'b11111 in N.
  - flush=1, flush_pc=32'hBFC00380, stall=0 in N+1.
  - flush=0 in N+2.
- Deferred flush: flush_req at N with mem_busy=1 held for 3 cycles:
  - stall=5'b11111 for N..N+3.
  - flush=1 only at N+4.
  - A second flush_req at N+2 with PC 32'h80000180 does not change flush_pc from the first value.
- Reset mid-operation: rst=0 during WAIT_BUS → flush never asserts, stall=0, stall_cycles=0. After release, stall_req_mem=1 → stall=5'b01111.
- Counter: stall_req_id=1 for 10 cycles → stall_cycles=10. With CNT_WIDTH=4 and 20 stall cycles → stall_cycles=4'hF, held there.
